// File: rtl/fir_result_drain_if.sv
// Output stream of fir_result_drain: first-word-fall-through head sample plus row/frame tags.
// Handshake: a word transfers on a rising clk edge where dout_vld && dout_rdy; while
// dout_vld is high and dout_rdy low, the master holds dout/dout_eol/dout_last stable.
interface fir_result_drain_if #(
    parameter int OUT_WIDTH = 16
);
    logic [OUT_WIDTH-1:0] dout;
    logic                 dout_vld;
    logic                 dout_rdy;
    logic                 dout_eol;
    logic                 dout_last;

    modport master (output dout, dout_vld, dout_eol, dout_last, input dout_rdy);
    modport slave  (input dout, dout_vld, dout_eol, dout_last, output dout_rdy);
endinterface

// File: rtl/fir_result_drain.sv
// Requantises FIR core results, tags row/frame ends, buffers them in a FWFT FIFO.
// Optional FIR_DRAIN_STATS_EN adds sat_cnt_o, a saturating count of clipped samples.
module fir_result_drain #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 8,
    parameter int OUT_ROWS   = 14,
    parameter int OUT_COLS   = 14,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] result_i,
    input  logic                result_vld_i,
    input  logic                result_finish_i,
    fir_result_drain_if.master  dout_if,
    output logic                done_o,
    output logic                overflow_o,
    output logic                frame_err_o,
    output logic                busy_o,
    output logic [1:0]          state_dbg_o
`ifdef FIR_DRAIN_STATS_EN
    ,
    output logic [15:0]         sat_cnt_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OUT_COLS + 1);
    localparam int RW = $clog2(OUT_ROWS + 1);
    localparam int EW = OUT_WIDTH + 2;
    localparam logic signed [IN_WIDTH:0] ROUND = (IN_WIDTH+1)'((64'd1 << SHIFT) >> 1);
    localparam logic signed [IN_WIDTH:0] MAX_Q = (IN_WIDTH+1)'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
    localparam logic signed [IN_WIDTH:0] MIN_Q = ~MAX_Q;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_cnt_q, col_cnt_d;
    logic [RW-1:0]          row_cnt_q, row_cnt_d;
    logic                   q_vld_q, q_vld_d;
    logic [EW-1:0]          q_data_q, q_data_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];

    logic signed [IN_WIDTH:0] rounded, shifted;
    logic                   sat_hi, sat_lo;
    logic [OUT_WIDTH-1:0]   q_sample;
    logic                   tag_eol, tag_last;
    logic                   accept, err_set, clr_cnt;
    logic                   empty, full, push, pop, drop;

    // Round half up, then clip to the signed output range.
    always_comb begin
        rounded = $signed({result_i[IN_WIDTH-1], result_i}) + ROUND;
        shifted = rounded >>> SHIFT;
        sat_hi  = (shifted > MAX_Q);
        sat_lo  = (shifted < MIN_Q);
        if (sat_hi)      q_sample = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (sat_lo) q_sample = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else             q_sample = shifted[OUT_WIDTH-1:0];
    end

    assign tag_eol  = (col_cnt_q == CW'(OUT_COLS - 1));
    assign tag_last = tag_eol && (row_cnt_q == RW'(OUT_ROWS - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        err_set = 1'b0;
        clr_cnt = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (result_vld_i) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
                if (result_vld_i && tag_last) begin
                    state_d = S_FLUSH;
                end else if (result_finish_i && (result_vld_i || state_q == S_RUN)) begin
                    err_set = 1'b1;
                    clr_cnt = 1'b1;
                    state_d = S_FLUSH;
                end else if (result_finish_i) begin
                    err_set = 1'b1;
                end
            end
            S_FLUSH: begin
                err_set = result_vld_i;
                if (!q_vld_q && empty) state_d = S_DONE;
            end
            S_DONE: begin
                err_set = result_vld_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (clr_cnt) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else if (accept) begin
            if (tag_eol) begin
                col_cnt_d = '0;
                row_cnt_d = tag_last ? '0 : row_cnt_q + RW'(1);
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end
        q_vld_d  = accept;
        q_data_d = accept ? {tag_last, tag_eol, q_sample} : q_data_q;
    end

    // A pop at full frees the slot for the same-cycle push.
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = !empty && dout_if.dout_rdy;
    assign push  = q_vld_q && (!full || pop);
    assign drop  = q_vld_q && full && !pop;

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
        overflow_d  = overflow_q | drop;
        frame_err_d = frame_err_q | err_set;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= q_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            q_vld_q     <= 1'b0;
            q_data_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            q_vld_q     <= q_vld_d;
            q_data_q    <= q_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef FIR_DRAIN_STATS_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (accept && (sat_hi || sat_lo) && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt_o = sat_cnt_q;
`endif

    // Head fields are forced to zero when empty so reset presents dout = 0.
    assign dout_if.dout      = empty ? '0 : mem_q[rd_ptr_q][OUT_WIDTH-1:0];
    assign dout_if.dout_eol  = !empty && mem_q[rd_ptr_q][OUT_WIDTH];
    assign dout_if.dout_last = !empty && mem_q[rd_ptr_q][OUT_WIDTH+1];
    assign dout_if.dout_vld  = !empty;

    assign done_o      = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
    assign state_dbg_o = state_q;
endmodule

// File: tb/tb_fir_result_drain.sv
// Directed testbench for fir_result_drain with default parameters.
// Popped words are captured on the falling edge and compared against hand-built expectations.
module tb_fir_result_drain;
    localparam int IW = 32;
    localparam int OW = 16;
    localparam int EW = OW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] result_i;
    logic          result_vld_i;
    logic          result_finish_i;
    logic          done_o, overflow_o, frame_err_o, busy_o;
    logic [1:0]    state_dbg;
`ifdef FIR_DRAIN_STATS_EN
    logic [15:0]   sat_cnt_o;
`endif

    fir_result_drain_if #(.OUT_WIDTH(OW)) dif ();

    fir_result_drain dut (
        .clk             (clk),
        .reset           (reset),
        .result_i        (result_i),
        .result_vld_i    (result_vld_i),
        .result_finish_i (result_finish_i),
        .dout_if         (dif),
        .done_o          (done_o),
        .overflow_o      (overflow_o),
        .frame_err_o     (frame_err_o),
        .busy_o          (busy_o),
        .state_dbg_o     (state_dbg)
`ifdef FIR_DRAIN_STATS_EN
        ,
        .sat_cnt_o       (sat_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    logic [EW-1:0] got_q[$];
    logic [EW-1:0] exp_q[$];

    // A word seen valid and ready mid-cycle pops on the next rising edge.
    always @(negedge clk) begin
        if (dif.dout_vld && dif.dout_rdy) got_q.push_back({dif.dout_last, dif.dout_eol, dif.dout});
        if (done_o) done_cnt++;
    end

    function automatic logic [EW-1:0] mk(input logic [OW-1:0] s, input logic eol, input logic last);
        return {last, eol, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IW-1:0] v, input logic vld, input logic fin);
        result_i        = v;
        result_vld_i    = vld;
        result_finish_i = fin;
        tick();
        result_i        = '0;
        result_vld_i    = 1'b0;
        result_finish_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic wait_done(input int budget, input int start, input string name);
        int n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (done_cnt == start) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no done_o within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        dif.dout_rdy = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (dif.dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", dif.dout_vld); end
        n_checks++;
        if (dif.dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", dif.dout); end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_checks++;
        if ({overflow_o, frame_err_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00", {overflow_o, frame_err_o});
        end
        n_checks++;
        if ({dif.dout_eol, dif.dout_last} !== 2'b00) begin
            n_fail++; $display("FAIL reset_tags: got %b want 00", {dif.dout_eol, dif.dout_last});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_quantise();
        do_reset();
        dif.dout_rdy = 1'b1;
        result_i = 32'h0000_0180; result_vld_i = 1'b1;
        tick();
        n_checks++;
        if (dif.dout_vld !== 1'b0) begin n_fail++; $display("FAIL quant_latency1: vld %b want 0", dif.dout_vld); end
        result_i = 32'hFFFF_FE80;
        tick();
        n_checks++;
        if (dif.dout_vld !== 1'b1 || dif.dout !== 16'h0002) begin
            n_fail++; $display("FAIL quant_w0: vld %b dout %h want 1 0002", dif.dout_vld, dif.dout);
        end
        result_i = 32'h0000_0000;
        tick();
        n_checks++;
        if (dif.dout !== 16'hFFFF) begin n_fail++; $display("FAIL quant_w1: dout %h want ffff", dif.dout); end
        result_vld_i = 1'b0;
        tick();
        n_checks++;
        if (dif.dout_vld !== 1'b1 || dif.dout !== 16'h0000) begin
            n_fail++; $display("FAIL quant_w2: vld %b dout %h want 1 0000", dif.dout_vld, dif.dout);
        end
        tick();
        n_checks++;
        if (dif.dout_vld !== 1'b0) begin n_fail++; $display("FAIL quant_empty: vld %b want 0", dif.dout_vld); end
    endtask

    task automatic test_rounding();
        logic [IW-1:0] vin[6]  = '{32'h0000_007F, 32'h0000_0080, 32'hFFFF_FF80,
                                   32'hFFFF_FF7F, 32'h0000_017F, 32'hFFFF_FE7F};
        logic [OW-1:0] vexp[6] = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE};
        int base;
        do_reset();
        dif.dout_rdy = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(vexp[i], 1'b0, 1'b0));
            drive(vin[i], 1'b1, 1'b0);
        end
        repeat (6) tick();
        n_checks++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++; $display("FAIL round_count: got %0d words want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL round_w%0d: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [IW-1:0] vin[6]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h007F_FF7F,
                                   32'h007F_FF80, 32'hFF80_0000, 32'hFF7F_FF7F};
        logic [OW-1:0] vexp[6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        int base;
        do_reset();
        dif.dout_rdy = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(vexp[i], 1'b0, 1'b0));
            drive(vin[i], 1'b1, 1'b0);
`ifdef FIR_DRAIN_STATS_EN
            if (i == 1) begin
                n_checks++;
                if (sat_cnt_o !== 16'd2) begin n_fail++; $display("FAIL sat_cnt_two: got %0d want 2", sat_cnt_o); end
            end
`endif
        end
        repeat (6) tick();
`ifdef FIR_DRAIN_STATS_EN
        n_checks++;
        if (sat_cnt_o !== 16'd4) begin n_fail++; $display("FAIL sat_cnt_end: got %0d want 4", sat_cnt_o); end
`endif
        n_checks++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++; $display("FAIL sat_count: got %0d words want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL sat_w%0d: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_full_frame();
        int base, d0;
        do_reset();
        dif.dout_rdy = 1'b1;
        base = got_q.size();
        d0   = done_cnt;
        for (int i = 0; i < 196; i++) begin
            exp_q.push_back(mk(16'(i), (i % 14) == 13, i == 195));
            drive(32'(i) << 8, 1'b1, i == 195);
        end
        wait_done(40, d0, "full");
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b want 0", busy_o); end
        repeat (4) tick();
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt - d0); end
        n_checks++;
        if ({overflow_o, frame_err_o} !== 2'b00) begin
            n_fail++; $display("FAIL full_flags: got %b want 00", {overflow_o, frame_err_o});
        end
        n_checks++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++; $display("FAIL full_count: got %0d words want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL full_w%0d: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int base, d0;
        do_reset();
        dif.dout_rdy = 1'b0;
        base = got_q.size();
        d0   = done_cnt;
        for (int i = 0; i < 196; i++) begin
            if (i < 16) exp_q.push_back(mk(16'(i), (i % 14) == 13, 1'b0));
            drive(32'(i) << 8, 1'b1, 1'b0);
        end
        repeat (4) tick();
        n_checks++;
        if ({overflow_o, frame_err_o} !== 2'b10) begin
            n_fail++; $display("FAIL ovf_flags: got %b want 10", {overflow_o, frame_err_o});
        end
        n_checks++;
        if (busy_o !== 1'b1 || dif.dout_vld !== 1'b1) begin
            n_fail++; $display("FAIL ovf_hold: busy %b vld %b want 1 1", busy_o, dif.dout_vld);
        end
        dif.dout_rdy = 1'b1;
        wait_done(40, d0, "ovf");
        n_checks++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_count: got %0d words want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL ovf_w%0d: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_short_frame();
        int base, d0;
        do_reset();
        dif.dout_rdy = 1'b1;
        base = got_q.size();
        d0   = done_cnt;
        for (int i = 0; i < 50; i++) begin
            exp_q.push_back(mk(16'(i), (i % 14) == 13, 1'b0));
            drive(32'(i) << 8, 1'b1, 1'b0);
        end
        drive('0, 1'b0, 1'b1);
        n_checks++;
        if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", frame_err_o); end
        wait_done(20, d0, "short");
        tick();
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(mk(16'(100 + i), i == 13, 1'b0));
            drive(32'(100 + i) << 8, 1'b1, 1'b0);
        end
        repeat (6) tick();
        n_checks++;
        if ({overflow_o, frame_err_o} !== 2'b01) begin
            n_fail++; $display("FAIL short_flags: got %b want 01", {overflow_o, frame_err_o});
        end
        n_checks++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++; $display("FAIL short_count: got %0d words want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL short_w%0d: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_idle_finish();
        do_reset();
        drive('0, 1'b0, 1'b1);
        n_checks++;
        if (frame_err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_finish: err %b busy %b want 1 0", frame_err_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        dif.dout_rdy = 1'b0;
        drive('0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(32'(i + 1) << 8, 1'b1, 1'b0);
        repeat (2) tick();
        n_checks++;
        if (dif.dout_vld !== 1'b1 || frame_err_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: vld %b err %b busy %b want 1 1 1", dif.dout_vld, frame_err_o, busy_o);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (dif.dout_vld !== 1'b0 || busy_o !== 1'b0 || dif.dout !== 16'h0000) begin
            n_fail++; $display("FAIL mid_post: vld %b busy %b dout %h want 0 0 0000", dif.dout_vld, busy_o, dif.dout);
        end
        n_checks++;
        if ({overflow_o, frame_err_o} !== 2'b00) begin
            n_fail++; $display("FAIL mid_flags: got %b want 00", {overflow_o, frame_err_o});
        end
        dif.dout_rdy = 1'b1;
        tick();
        base = got_q.size();
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(mk(16'(200 + i), i == 13, 1'b0));
            drive(32'(200 + i) << 8, 1'b1, 1'b0);
        end
        repeat (6) tick();
        n_checks++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++; $display("FAIL mid_count: got %0d words want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL mid_w%0d: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        reset           = 1'b0;
        result_i        = '0;
        result_vld_i    = 1'b0;
        result_finish_i = 1'b0;
        dif.dout_rdy    = 1'b0;
        test_reset();
        test_quantise();
        test_rounding();
        test_saturate();
        test_full_frame();
        test_overflow();
        test_short_frame();
        test_idle_finish();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
